// File: rtl/fpa64_result_scoreboard.sv
// fpa64_result_scoreboard
//   Checking stage for the 64-bit pipelined FP adder. The expected sum for every
//   operand pair issued to the adder is pushed into a small FIFO. A valid delay
//   line tells us when the matching adder result arrives. On that edge the FIFO
//   head is compared with the result and the pass/fail counts are updated. The
//   first mismatch is captured. done rises after N_TESTS checks.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous reset, active-high
//   issue_valid     an operand pair is presented to the adder this edge
//   issue_expected  expected IEEE-754 double sum for that pair
//   result          adder result bus
//   pass_count      number of matching checks (saturating)
//   fail_count      number of mismatching checks (saturating)
//   first_fail_idx  0-based check index of the first mismatch
//   first_fail_got  adder result at the first mismatch
//   first_fail_exp  expected value at the first mismatch
//   overflow        sticky: an issue arrived while the FIFO was full and was dropped
//   underflow       sticky: a result was due while the FIFO was empty
//   done            N_TESTS checks have completed
//   correct         done with no failures, no overflow and no underflow
module fpa64_result_scoreboard #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 8,
  parameter int N_TESTS = 8,
  parameter int CNT_W   = 8,
  parameter bit ZERO_EQ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [63:0]      issue_expected,
  input  logic [63:0]      result,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [63:0]      first_fail_got,
  output logic [63:0]      first_fail_exp,
  output logic             overflow,
  output logic             underflow,
  output logic             done,
  output logic             correct
);

  // DEPTH is a power of two of at least 2, so the index field of a pointer is never empty.
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;

  logic [63:0]        mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [LATENCY-1:0] dly;

  logic           active;
  logic           due;
  logic           empty;
  logic           full;
  logic           pop;
  logic           push;
  logic           match;
  logic           last_check;
  logic [63:0]    head;
  logic [CNT_W:0] checks;

  assign active = (state != DONE);
  assign due    = dly[LATENCY-1];

  // The extra pointer bit separates the full and empty cases when the index bits are equal.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same edge frees a slot, so a push into a full FIFO is allowed then.
  assign pop  = active && due && !empty;
  assign push = active && issue_valid && (!full || pop);

  assign head = mem[rd_ptr[AW-1:0]];

  // Optionally +0 and -0 compare equal. All other patterns, NaNs included, need an exact bit match.
  assign match = (head == result) ||
                 (ZERO_EQ && (head[62:0] == 63'd0) && (result[62:0] == 63'd0));

  assign checks     = {1'b0, pass_count} + {1'b0, fail_count};
  assign last_check = pop && (checks == (CNT_W+1)'(N_TESTS - 1));

  assign correct = done && (fail_count == '0) && !overflow && !underflow;

  // Expected-value storage. Every slot is written before it is read, so it has no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= issue_expected;
    end
  end

  // Control, delay line, counters and the first-failure capture. Once DONE is reached,
  // pop and push stay low, so everything except the draining delay line is frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      dly            <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_got <= '0;
      first_fail_exp <= '0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
      done           <= 1'b0;
    end else begin
      dly <= (dly << 1) | LATENCY'(push);

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      if (active && issue_valid && full && !pop) begin
        overflow <= 1'b1;
      end
      if (active && due && empty) begin
        underflow <= 1'b1;
      end

      if (pop) begin
        if (match) begin
          if (pass_count != CNT_MAX) begin
            pass_count <= pass_count + CNT_W'(1);
          end
        end else begin
          if (fail_count != CNT_MAX) begin
            fail_count <= fail_count + CNT_W'(1);
          end
          if (fail_count == '0) begin
            first_fail_idx <= checks[CNT_W-1:0];
            first_fail_got <= result;
            first_fail_exp <= head;
          end
        end
      end

      if (last_check) begin
        done <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (last_check) begin
            state <= DONE;
          end else if (issue_valid) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (last_check) begin
            state <= DONE;
          end
        end
        default: state <= DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpa64_result_scoreboard.sv
// tb_fpa64_result_scoreboard
//   Drives an adder-like result stream into two scoreboard builds. The main build uses
//   the default parameters. The alternate build has DEPTH=2 and ZERO_EQ=0. The main
//   build is checked on every edge against a list-based model. The model records the
//   issue edge and the expected/returned value of each pair. From those lists it derives
//   how many checks should have completed, and how many passed, by any given edge.
`timescale 1ns/1ps
module tb_fpa64_result_scoreboard;

  localparam int LAT = 3;
  localparam int NT  = 8;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [63:0]   issue_expected;
  logic [63:0]   result;

  logic [CW-1:0] m_pass, m_fail, m_idx;
  logic [63:0]   m_got, m_exp;
  logic          m_ovf, m_unf, m_done, m_correct;

  logic [CW-1:0] a_pass, a_fail, a_idx;
  logic [63:0]   a_got, a_exp;
  logic          a_ovf, a_unf, a_done, a_correct;

  int compared   = 0;
  int mismatched = 0;
  int edge_no    = 0;

  // Result values scheduled by absolute edge number, emulating the adder pipeline.
  logic [63:0] sched [256];

  // Model lists for the current run: issue edge, expected sum and returned sum.
  int          iss_edge[$];
  logic [63:0] iss_exp[$];
  logic [63:0] iss_got[$];

  always #5 clk = ~clk;

  fpa64_result_scoreboard #(
    .LATENCY(LAT), .DEPTH(8), .N_TESTS(NT), .CNT_W(CW), .ZERO_EQ(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_expected(issue_expected),
    .result(result), .pass_count(m_pass), .fail_count(m_fail), .first_fail_idx(m_idx),
    .first_fail_got(m_got), .first_fail_exp(m_exp), .overflow(m_ovf), .underflow(m_unf),
    .done(m_done), .correct(m_correct)
  );

  fpa64_result_scoreboard #(
    .LATENCY(LAT), .DEPTH(2), .N_TESTS(NT), .CNT_W(CW), .ZERO_EQ(1'b0)
  ) dut_alt (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_expected(issue_expected),
    .result(result), .pass_count(a_pass), .fail_count(a_fail), .first_fail_idx(a_idx),
    .first_fail_got(a_got), .first_fail_exp(a_exp), .overflow(a_ovf), .underflow(a_unf),
    .done(a_done), .correct(a_correct)
  );

  // Equality as seen by the main build: exact bits, except that +0 and -0 are equal.
  function automatic logic zeq(input logic [63:0] a, input logic [63:0] b);
    return (a == b) || ((a[62:0] == 63'd0) && (b[62:0] == 63'd0));
  endfunction

  // A pair issued at edge k is checked at edge k+LAT. Checks stop once NT have completed.
  function automatic int checks_by(input int t);
    int n = 0;
    foreach (iss_edge[i]) if (iss_edge[i] + LAT <= t) n++;
    return (n > NT) ? NT : n;
  endfunction

  function automatic int passes_by(input int t);
    int n = checks_by(t);
    int p = 0;
    for (int i = 0; i < n; i++) if (zeq(iss_exp[i], iss_got[i])) p++;
    return p;
  endfunction

  // One clock: drive the issue and the due adder result, then advance past the edge.
  task automatic step(input logic v, input logic [63:0] e, input logic [63:0] g);
    @(negedge clk);
    issue_valid    = v;
    issue_expected = e;
    result         = sched[edge_no % 256];
    if (v) begin
      sched[(edge_no + LAT) % 256] = g;
      iss_edge.push_back(edge_no);
      iss_exp.push_back(e);
      iss_got.push_back(g);
    end
    @(posedge clk);
    edge_no++;
    #1;
  endtask

  // Reset for one edge and start a new model run. Scheduled results are deliberately
  // left in place so that stale in-flight results still reach the result bus.
  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    issue_valid = 1'b0;
    @(posedge clk);
    edge_no++;
    #1;
    rst = 1'b0;
    iss_edge.delete();
    iss_exp.delete();
    iss_got.delete();
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    do_reset();
    compared++;
    if ({m_pass, m_fail, m_idx} !== '0 || {m_done, m_correct, m_ovf, m_unf} !== 4'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_main: pass=%0d fail=%0d idx=%0d flags=%b, want all 0",
               m_pass, m_fail, m_idx, {m_done, m_correct, m_ovf, m_unf});
    end
    compared++;
    if ({m_got, m_exp} !== 128'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_capture: got=%h exp=%h, want 0", m_got, m_exp);
    end
    compared++;
    if ({a_pass, a_fail, a_idx} !== '0 || {a_done, a_correct, a_ovf, a_unf} !== 4'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_alt: pass=%0d fail=%0d flags=%b, want all 0",
               a_pass, a_fail, {a_done, a_correct, a_ovf, a_unf});
    end
  endtask

  task automatic test_back_to_back();
    int ec, ep;
    do_reset();
    for (int i = 0; i < NT + LAT + 2; i++) begin
      if (i < NT) step(1'b1, 64'h4066800000000000, 64'h4066800000000000);
      else        step(1'b0, 64'h0, 64'h0);
      ec = checks_by(edge_no - 1);
      ep = passes_by(edge_no - 1);
      compared++;
      if (m_pass !== CW'(ep) || m_fail !== CW'(ec - ep) || m_done !== (ec == NT)) begin
        mismatched++;
        $display("[TB] FAIL b2b_step%0d: pass=%0d fail=%0d done=%b, want pass=%0d fail=%0d done=%b",
                 i, m_pass, m_fail, m_done, ep, ec - ep, ec == NT);
      end
    end
    compared++;
    if (m_pass !== 8'd8 || m_fail !== 8'd0 || m_correct !== 1'b1 || m_ovf !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_final: pass=%0d fail=%0d correct=%b ovf=%b, want 8 0 1 0",
               m_pass, m_fail, m_correct, m_ovf);
    end
  endtask

  task automatic test_zero_equal();
    do_reset();
    step(1'b1, 64'h0, 64'h8000000000000000);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 64'h0, 64'h0);
    compared++;
    if (m_pass !== 8'd1 || m_fail !== 8'd0 || m_done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL zero_eq1: pass=%0d fail=%0d done=%b, want 1 0 0", m_pass, m_fail, m_done);
    end
    compared++;
    if (a_pass !== 8'd0 || a_fail !== 8'd1 || a_idx !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL zero_eq0_counts: pass=%0d fail=%0d idx=%0d, want 0 1 0", a_pass, a_fail, a_idx);
    end
    compared++;
    if (a_got !== 64'h8000000000000000 || a_exp !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL zero_eq0_capture: got=%h exp=%h, want 8000000000000000 0", a_got, a_exp);
    end
  endtask

  task automatic test_first_fail();
    int ec, ep;
    logic [63:0] e;
    do_reset();
    for (int i = 0; i < NT + LAT + 2; i++) begin
      if (i == 2) begin
        step(1'b1, 64'h4051800000000000, 64'h4051800000000001);
      end else if (i < NT) begin
        e = rand64();
        step(1'b1, e, e);
      end else begin
        step(1'b0, 64'h0, 64'h0);
      end
      ec = checks_by(edge_no - 1);
      ep = passes_by(edge_no - 1);
      compared++;
      if (m_pass !== CW'(ep) || m_fail !== CW'(ec - ep) || m_done !== (ec == NT)) begin
        mismatched++;
        $display("[TB] FAIL ffail_step%0d: pass=%0d fail=%0d done=%b, want pass=%0d fail=%0d done=%b",
                 i, m_pass, m_fail, m_done, ep, ec - ep, ec == NT);
      end
    end
    compared++;
    if (m_fail !== 8'd1 || m_idx !== 8'd2 || m_pass !== 8'd7 || m_done !== 1'b1 || m_correct !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ffail_final: fail=%0d idx=%0d pass=%0d done=%b correct=%b, want 1 2 7 1 0",
               m_fail, m_idx, m_pass, m_done, m_correct);
    end
    compared++;
    if (m_got !== 64'h4051800000000001 || m_exp !== 64'h4051800000000000) begin
      mismatched++;
      $display("[TB] FAIL ffail_capture: got=%h exp=%h, want 4051800000000001 4051800000000000", m_got, m_exp);
    end
  endtask

  task automatic test_gapped();
    int ec, ep;
    int issued = 0;
    logic v;
    logic [63:0] e;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      v = (issued < NT) && (i >= 20 || $urandom_range(0, 2) != 0);
      e = rand64();
      step(v, e, e);
      if (v) issued++;
      ec = checks_by(edge_no - 1);
      ep = passes_by(edge_no - 1);
      compared++;
      if (m_pass !== CW'(ep) || m_fail !== CW'(ec - ep) || m_done !== (ec == NT)) begin
        mismatched++;
        $display("[TB] FAIL gapped_step%0d: pass=%0d fail=%0d done=%b, want pass=%0d fail=%0d done=%b",
                 i, m_pass, m_fail, m_done, ep, ec - ep, ec == NT);
      end
    end
    compared++;
    if (m_pass !== 8'd8 || m_correct !== 1'b1 || m_unf !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL gapped_final: pass=%0d correct=%b unf=%b, want 8 1 0", m_pass, m_correct, m_unf);
    end
  endtask

  task automatic test_overflow();
    int ec, ep;
    logic [63:0] e;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      e = rand64();
      step(1'b1, e, e);
      ec = checks_by(edge_no - 1);
      ep = passes_by(edge_no - 1);
      compared++;
      if (m_pass !== CW'(ep) || m_fail !== CW'(ec - ep) || m_done !== (ec == NT)) begin
        mismatched++;
        $display("[TB] FAIL ovf_main_step%0d: pass=%0d fail=%0d done=%b, want pass=%0d fail=%0d done=%b",
                 i, m_pass, m_fail, m_done, ep, ec - ep, ec == NT);
      end
    end
    compared++;
    if (m_ovf !== 1'b0 || m_correct !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL ovf_main_flags: ovf=%b correct=%b, want 0 1", m_ovf, m_correct);
    end
    compared++;
    if (a_ovf !== 1'b1 || a_done !== 1'b1 || a_correct !== 1'b0 || a_unf !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ovf_alt_flags: ovf=%b done=%b correct=%b unf=%b, want 1 1 0 0",
               a_ovf, a_done, a_correct, a_unf);
    end
    compared++;
    if (a_pass !== 8'd8 || a_fail !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL ovf_alt_counts: pass=%0d fail=%0d, want 8 0", a_pass, a_fail);
    end
  endtask

  task automatic test_reset_mid_run();
    int ec, ep;
    logic [63:0] e;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      e = rand64();
      step(1'b1, e, e);
    end
    compared++;
    if (m_pass !== 8'd4 || m_fail !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL midrst_before: pass=%0d fail=%0d, want 4 0", m_pass, m_fail);
    end
    do_reset();
    compared++;
    if (m_pass !== 8'd0 || m_fail !== 8'd0 || m_done !== 1'b0 || m_correct !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midrst_cleared: pass=%0d fail=%0d done=%b correct=%b, want 0 0 0 0",
               m_pass, m_fail, m_done, m_correct);
    end
    for (int i = 0; i < LAT + 1 + NT + LAT + 2; i++) begin
      if (i > LAT && i <= LAT + NT) begin
        e = rand64();
        step(1'b1, e, e);
      end else begin
        step(1'b0, 64'h0, 64'h0);
      end
      ec = checks_by(edge_no - 1);
      ep = passes_by(edge_no - 1);
      compared++;
      if (m_pass !== CW'(ep) || m_fail !== CW'(ec - ep) || m_done !== (ec == NT) || m_unf !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL midrst_step%0d: pass=%0d fail=%0d done=%b unf=%b, want pass=%0d fail=%0d done=%b unf=0",
                 i, m_pass, m_fail, m_done, m_unf, ep, ec - ep, ec == NT);
      end
    end
    compared++;
    if (m_pass !== 8'd8 || m_correct !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midrst_final: pass=%0d correct=%b, want 8 1", m_pass, m_correct);
    end
  endtask

  initial begin
    rst            = 1'b1;
    issue_valid    = 1'b0;
    issue_expected = 64'h0;
    result         = 64'h0;
    for (int i = 0; i < 256; i++) sched[i] = 64'h0;
    $display("[TB] starting fpa64_result_scoreboard bench");
    test_reset();
    test_back_to_back();
    test_zero_equal();
    test_first_fail();
    test_gapped();
    test_overflow();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
